// File: rtl/addr_bus_pkg.sv
// addr_bus_pkg: shared FSM state type and default constants for the address bus arbiter.
package addr_bus_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, DRIVE} state_e;
    localparam int ADDR_BUS_WIDTH = 16;
    localparam int ADDR_BUS_SETTLE_CYCLES = 2;
endpackage

// File: rtl/addr_bus_prio_enc.sv
// addr_bus_prio_enc: fixed-priority one-hot encoder (lowest index wins) with any/multiple request flags.
module addr_bus_prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         any_o,
    output logic         multi_o
);
    // two's complement isolates the lowest set bit
    assign grant_o = req_i & (~req_i + N'(1));
    assign any_o   = |req_i;
    assign multi_o = |(req_i & ~grant_o);
endmodule

// File: rtl/addr_bus_arbiter.sv
// addr_bus_arbiter: fixed-priority relay address bus arbiter with settle delay and release turnaround.
// Define ADDR_BUS_CONTENTION_EN to add the contention pulse and saturating contention counter.
module addr_bus_arbiter
    import addr_bus_pkg::*;
#(
    parameter int ADDR_WIDTH    = ADDR_BUS_WIDTH,
    parameter int N_SRC         = 5,
    parameter int SETTLE_CYCLES = ADDR_BUS_SETTLE_CYCLES
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_SRC-1:0]                  src_req_i,
    input  logic [N_SRC-1:0][ADDR_WIDTH-1:0]  src_addr_i,
    output logic [N_SRC-1:0]                  src_grant_o,
    output logic [ADDR_WIDTH-1:0]             addr_out_o,
    output logic                              addr_valid_o,
    output logic                              bus_busy_o
`ifdef ADDR_BUS_CONTENTION_EN
    ,
    output logic                              contention_o,
    output logic [7:0]                        contention_cnt_o
`endif
);
    state_e                state_q, state_d;
    logic [3:0]            settle_cnt_q, settle_cnt_d;
    logic [N_SRC-1:0]      grant_q, grant_d, pick, sel;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, mux;
    logic                  any, multi;

    addr_bus_prio_enc #(.N(N_SRC)) u_enc (
        .req_i  (src_req_i),
        .grant_o(pick),
        .any_o  (any),
        .multi_o(multi)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            grant_q      <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
        end

    always_comb begin
        // only the owning source (or the one about to be granted) is muxed onto the bus
        sel = (state_q == IDLE) ? pick : grant_q;
        mux = '0;
        for (int i = 0; i < N_SRC; i++) mux |= sel[i] ? src_addr_i[i] : '0;
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        grant_d      = grant_q;
        addr_d       = mux;
        if (state_q == IDLE) begin
            grant_d      = pick;
            state_d      = !any ? IDLE : (SETTLE_CYCLES > 0) ? SETTLE : DRIVE;
            settle_cnt_d = any ? 4'(SETTLE_CYCLES) : '0;
        end else if (!(|(src_req_i & grant_q))) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
            grant_d      = '0;
            addr_d       = '0;
        end else if (state_q == SETTLE) begin
            state_d      = (settle_cnt_q == 4'd1) ? DRIVE : SETTLE;
            settle_cnt_d = settle_cnt_q - 4'd1;
        end
    end

    always_comb begin
        src_grant_o  = grant_q;
        addr_out_o   = addr_q;
        addr_valid_o = state_q == DRIVE;
        bus_busy_o   = state_q != IDLE;
    end

`ifdef ADDR_BUS_CONTENTION_EN
    logic       contention_q, contention_d;
    logic [7:0] contention_cnt_q, contention_cnt_d;

    always_comb begin
        contention_d     = state_q == IDLE && multi;
        contention_cnt_d = contention_cnt_q + 8'((contention_d && contention_cnt_q != 8'hff) ? 1 : 0);
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            contention_q     <= 1'b0;
            contention_cnt_q <= '0;
        end else begin
            contention_q     <= contention_d;
            contention_cnt_q <= contention_cnt_d;
        end

    assign contention_o     = contention_q;
    assign contention_cnt_o = contention_cnt_q;
`else
    logic unused_multi;
    assign unused_multi = multi;
`endif
endmodule

// File: tb/tb_addr_bus_arbiter.sv
// tb_addr_bus_arbiter: directed tests of the address bus arbiter at SETTLE_CYCLES=2/16-bit and SETTLE_CYCLES=0/8-bit.
module tb_addr_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] req0 = '0, req1 = '0;
    logic [4:0][15:0] a0 = '0;
    logic [4:0][7:0] a1 = '0;
    logic [4:0] g0, g1;
    logic [15:0] o0;
    logic [7:0] o1;
    logic v0, v1, b0, b1;
`ifdef ADDR_BUS_CONTENTION_EN
    logic c0, c1;
    logic [7:0] cc0, cc1;
`endif
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    addr_bus_arbiter #(.ADDR_WIDTH(16), .N_SRC(5), .SETTLE_CYCLES(2)) u0 (
        .clk_i(clk), .rst_i(rst), .src_req_i(req0), .src_addr_i(a0),
        .src_grant_o(g0), .addr_out_o(o0), .addr_valid_o(v0), .bus_busy_o(b0)
`ifdef ADDR_BUS_CONTENTION_EN
        , .contention_o(c0), .contention_cnt_o(cc0)
`endif
    );

    addr_bus_arbiter #(.ADDR_WIDTH(8), .N_SRC(5), .SETTLE_CYCLES(0)) u1 (
        .clk_i(clk), .rst_i(rst), .src_req_i(req1), .src_addr_i(a1),
        .src_grant_o(g1), .addr_out_o(o1), .addr_valid_o(v1), .bus_busy_o(b1)
`ifdef ADDR_BUS_CONTENTION_EN
        , .contention_o(c1), .contention_cnt_o(cc1)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step();
        step();
        total++; if ({g0, o0, v0, b0} !== 23'd0) begin bad++; $display("FAIL reset_u0 got=%h exp=%h", {g0, o0, v0, b0}, 23'd0); end
        total++; if ({g1, o1, v1, b1} !== 15'd0) begin bad++; $display("FAIL reset_u1 got=%h exp=%h", {g1, o1, v1, b1}, 15'd0); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        a0 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1234};
        req0 = 5'b00001;
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b00001, 16'h1234, 1'b0, 1'b1}) begin bad++; $display("FAIL single_k got=%h exp=%h", {g0, o0, v0, b0}, {5'b00001, 16'h1234, 1'b0, 1'b1}); end
        step();
        total++; if ({g0, v0, b0} !== {5'b00001, 1'b0, 1'b1}) begin bad++; $display("FAIL single_k1 got=%h exp=%h", {g0, v0, b0}, {5'b00001, 1'b0, 1'b1}); end
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b00001, 16'h1234, 1'b1, 1'b1}) begin bad++; $display("FAIL single_k2 got=%h exp=%h", {g0, o0, v0, b0}, {5'b00001, 16'h1234, 1'b1, 1'b1}); end
        a0[0] = 16'hBEEF;
        step();
        total++; if ({o0, v0, b0} !== {16'hBEEF, 1'b1, 1'b1}) begin bad++; $display("FAIL drive_addr_change got=%h exp=%h", {o0, v0, b0}, {16'hBEEF, 1'b1, 1'b1}); end
        req0 = '0;
        step();
        total++; if ({g0, o0, v0, b0} !== 23'd0) begin bad++; $display("FAIL single_release got=%h exp=%h", {g0, o0, v0, b0}, 23'd0); end
    endtask

    task automatic test_priority();
        req0 = 5'b10100;
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b00100, 16'h3333, 1'b0, 1'b1}) begin bad++; $display("FAIL prio_grant got=%h exp=%h", {g0, o0, v0, b0}, {5'b00100, 16'h3333, 1'b0, 1'b1}); end
`ifdef ADDR_BUS_CONTENTION_EN
        total++; if ({c0, cc0} !== {1'b1, 8'd1}) begin bad++; $display("FAIL contention_pulse got=%h exp=%h", {c0, cc0}, {1'b1, 8'd1}); end
`endif
        step();
`ifdef ADDR_BUS_CONTENTION_EN
        total++; if ({c0, cc0} !== {1'b0, 8'd1}) begin bad++; $display("FAIL contention_end got=%h exp=%h", {c0, cc0}, {1'b0, 8'd1}); end
`endif
        step();
        total++; if ({g0, o0, v0} !== {5'b00100, 16'h3333, 1'b1}) begin bad++; $display("FAIL prio_drive got=%h exp=%h", {g0, o0, v0}, {5'b00100, 16'h3333, 1'b1}); end
        req0 = '0;
        step();
    endtask

    task automatic test_no_preempt();
        req0 = 5'b00001;
        step(); step(); step();
        total++; if ({g0, v0} !== {5'b00001, 1'b1}) begin bad++; $display("FAIL np_drive got=%h exp=%h", {g0, v0}, {5'b00001, 1'b1}); end
        req0 = 5'b01001;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({g0, o0, v0} !== {5'b00001, 16'hBEEF, 1'b1}) begin bad++; $display("FAIL np_hold got=%h exp=%h", {g0, o0, v0}, {5'b00001, 16'hBEEF, 1'b1}); end
        end
        req0 = 5'b01000;
        step();
        total++; if ({g0, o0, v0, b0} !== 23'd0) begin bad++; $display("FAIL np_turnaround got=%h exp=%h", {g0, o0, v0, b0}, 23'd0); end
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b01000, 16'h4444, 1'b0, 1'b1}) begin bad++; $display("FAIL np_regrant got=%h exp=%h", {g0, o0, v0, b0}, {5'b01000, 16'h4444, 1'b0, 1'b1}); end
        req0 = '0;
        step();
    endtask

    task automatic test_settle_drop();
        req0 = 5'b00010;
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b00010, 16'h2222, 1'b0, 1'b1}) begin bad++; $display("FAIL sd_grant got=%h exp=%h", {g0, o0, v0, b0}, {5'b00010, 16'h2222, 1'b0, 1'b1}); end
        req0 = '0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if ({g0, o0, v0, b0} !== 23'd0) begin bad++; $display("FAIL sd_idle got=%h exp=%h", {g0, o0, v0, b0}, 23'd0); end
        end
    endtask

    task automatic test_async_reset();
        req0 = 5'b00001;
        step(); step(); step();
        total++; if (v0 !== 1'b1) begin bad++; $display("FAIL ar_drive got=%b exp=1", v0); end
        #2 rst = 1'b1;
        #1;
        total++; if ({g0, o0, v0, b0} !== 23'd0) begin bad++; $display("FAIL ar_u0 got=%h exp=%h", {g0, o0, v0, b0}, 23'd0); end
        total++; if ({g1, o1, v1, b1} !== 15'd0) begin bad++; $display("FAIL ar_u1 got=%h exp=%h", {g1, o1, v1, b1}, 15'd0); end
`ifdef ADDR_BUS_CONTENTION_EN
        total++; if ({c0, cc0} !== 9'd0) begin bad++; $display("FAIL ar_cont got=%h exp=0", {c0, cc0}); end
`endif
        #2 rst = 1'b0;
        step();
        total++; if ({g0, o0, v0, b0} !== {5'b00001, 16'hBEEF, 1'b0, 1'b1}) begin bad++; $display("FAIL ar_first_edge got=%h exp=%h", {g0, o0, v0, b0}, {5'b00001, 16'hBEEF, 1'b0, 1'b1}); end
        req0 = '0;
        step();
    endtask

    task automatic test_zero_settle();
        a1 = {8'h55, 8'h44, 8'h33, 8'hC3, 8'h5A};
        req1 = 5'b00011;
        step();
        total++; if ({g1, o1, v1, b1} !== {5'b00001, 8'h5A, 1'b1, 1'b1}) begin bad++; $display("FAIL zs_grant got=%h exp=%h", {g1, o1, v1, b1}, {5'b00001, 8'h5A, 1'b1, 1'b1}); end
`ifdef ADDR_BUS_CONTENTION_EN
        total++; if ({c1, cc1} !== {1'b1, 8'd1}) begin bad++; $display("FAIL zs_cont1 got=%h exp=%h", {c1, cc1}, {1'b1, 8'd1}); end
`endif
        req1 = '0;
        step();
        total++; if ({g1, o1, v1, b1} !== 15'd0) begin bad++; $display("FAIL zs_release got=%h exp=%h", {g1, o1, v1, b1}, 15'd0); end
`ifdef ADDR_BUS_CONTENTION_EN
        for (int i = 0; i < 300; i++) begin
            req1 = 5'b00011;
            step();
            req1 = '0;
            step();
        end
        total++; if ({c1, cc1} !== {1'b0, 8'd255}) begin bad++; $display("FAIL zs_saturate got=%h exp=%h", {c1, cc1}, {1'b0, 8'd255}); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_settle_drop();
        test_async_reset();
        test_zero_settle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
